jt51_op_wr_sched: RTL and testbench

// - Write initiator for the per-operator register ring: takes CPU writes to

---
 rtl/jt51_op_wr_sched.sv | 181 ++++++++++++++++++
 tb/tb_jt51_op_wr_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_op_wr_sched.sv
// Operator register write scheduler: holds one CPU write and strobes the ring when
// the target operator reaches the write point. Define JT51_WR_QUEUE_EN for a one-entry queue.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | nothing pending, next write >= 0x40 is latched
// ST_PEND | write latched, waiting for the ring slot of its operator
module jt51_op_wr_sched #(
    parameter int unsigned SLOT_OFS = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cen_i,
    input  logic       wr_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] din_i,
    output logic       busy_o,
    output logic       ovf_o,
    output logic [7:0] dout_o,
    output logic       up_dt1_op_o,
    output logic       up_mul_op_o,
    output logic       up_tl_op_o,
    output logic       up_ks_op_o,
    output logic       up_amsen_op_o,
    output logic       up_dt2_op_o,
    output logic       up_d1l_op_o,
    output logic       up_ar_op_o,
    output logic       up_d1r_op_o,
    output logic       up_d2r_op_o,
    output logic       up_rr_op_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t     state_q;
    logic [4:0] cnt_q;
    logic [4:0] slot_q;
    logic [2:0] grp_q;
    logic [7:0] dout_q;
    logic       ovf_q;

`ifdef JT51_WR_QUEUE_EN
    logic       q_vld_q;
    logic [7:0] q_addr_q;
    logic [7:0] q_din_q;
`endif

    // Register order M1,M2,C1,C2 becomes ring order M1,C1,M2,C2 by swapping addr[4:3].
    function automatic logic [4:0] slot_of(input logic [7:0] a);
        logic [4:0] tgt;
        tgt = {a[3], a[4], a[2:0]};
        return tgt + 5'(SLOT_OFS);
    endfunction

    logic wr_ok;
    logic fire;
    logic done;

    assign wr_ok = wr_i & (addr_i[7] | addr_i[6]);
    assign fire  = (state_q == ST_PEND) && (cnt_q == slot_q);
    assign done  = fire & cen_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            slot_q   <= '0;
            grp_q    <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
`ifdef JT51_WR_QUEUE_EN
            q_vld_q  <= 1'b0;
            q_addr_q <= '0;
            q_din_q  <= '0;
`endif
        end else begin
            if (cen_i) begin
                cnt_q <= cnt_q + 5'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (wr_ok) begin
                        state_q <= ST_PEND;
                        slot_q  <= slot_of(addr_i);
                        grp_q   <= addr_i[7:5];
                        dout_q  <= din_i;
                    end
                end
                ST_PEND: begin
`ifdef JT51_WR_QUEUE_EN
                    if (done) begin
                        // Completion hands over straight to the next write, no idle gap.
                        if (q_vld_q) begin
                            slot_q  <= slot_of(q_addr_q);
                            grp_q   <= q_addr_q[7:5];
                            dout_q  <= q_din_q;
                            q_vld_q <= 1'b0;
                            if (wr_ok) begin
                                ovf_q <= 1'b1;
                            end
                        end else if (wr_ok) begin
                            slot_q <= slot_of(addr_i);
                            grp_q  <= addr_i[7:5];
                            dout_q <= din_i;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (wr_ok) begin
                        if (q_vld_q) begin
                            ovf_q <= 1'b1;
                        end else begin
                            q_vld_q  <= 1'b1;
                            q_addr_q <= addr_i;
                            q_din_q  <= din_i;
                        end
                    end
`else
                    if (wr_ok) begin
                        ovf_q <= 1'b1;
                    end
                    if (done) begin
                        state_q <= ST_IDLE;
                    end
`endif
                end
            endcase
        end
    end

`ifdef JT51_WR_QUEUE_EN
    assign busy_o = q_vld_q;
`else
    assign busy_o = (state_q == ST_PEND);
`endif
    assign ovf_o  = ovf_q;
    assign dout_o = dout_q;

    always_comb begin
        up_dt1_op_o   = 1'b0;
        up_mul_op_o   = 1'b0;
        up_tl_op_o    = 1'b0;
        up_ks_op_o    = 1'b0;
        up_amsen_op_o = 1'b0;
        up_dt2_op_o   = 1'b0;
        up_d1l_op_o   = 1'b0;
        up_ar_op_o    = 1'b0;
        up_d1r_op_o   = 1'b0;
        up_d2r_op_o   = 1'b0;
        up_rr_op_o    = 1'b0;
        if (fire) begin
            case (grp_q)
                3'b010: begin
                    up_dt1_op_o = 1'b1;
                    up_mul_op_o = 1'b1;
                end
                3'b011: up_tl_op_o = 1'b1;
                3'b100: begin
                    up_ks_op_o = 1'b1;
                    up_ar_op_o = 1'b1;
                end
                3'b101: begin
                    up_amsen_op_o = 1'b1;
                    up_d1r_op_o   = 1'b1;
                end
                3'b110: begin
                    up_dt2_op_o = 1'b1;
                    up_d2r_op_o = 1'b1;
                end
                3'b111: begin
                    up_d1l_op_o = 1'b1;
                    up_rr_op_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt51_op_wr_sched.sv
// Scoreboard bench for jt51_op_wr_sched: two instances (slot offsets 0 and 5) share
// stimulus; a list-based reference model predicts strobes, busy, ovf and dout.
module tb_jt51_op_wr_sched;

    localparam int OFS0 = 0;
    localparam int OFS1 = 5;
`ifdef JT51_WR_QUEUE_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  din;
    logic        busy0, ovf0, busy1, ovf1;
    logic [7:0]  dout0, dout1;
    logic [10:0] up0, up1;

    always #5 clk = ~clk;

    jt51_op_wr_sched #(.SLOT_OFS(OFS0)) u0 (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .wr_i(wr), .addr_i(addr), .din_i(din),
        .busy_o(busy0), .ovf_o(ovf0), .dout_o(dout0),
        .up_dt1_op_o(up0[10]), .up_mul_op_o(up0[9]), .up_tl_op_o(up0[8]),
        .up_ks_op_o(up0[7]), .up_amsen_op_o(up0[6]), .up_dt2_op_o(up0[5]),
        .up_d1l_op_o(up0[4]), .up_ar_op_o(up0[3]), .up_d1r_op_o(up0[2]),
        .up_d2r_op_o(up0[1]), .up_rr_op_o(up0[0])
    );

    jt51_op_wr_sched #(.SLOT_OFS(OFS1)) u1 (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .wr_i(wr), .addr_i(addr), .din_i(din),
        .busy_o(busy1), .ovf_o(ovf1), .dout_o(dout1),
        .up_dt1_op_o(up1[10]), .up_mul_op_o(up1[9]), .up_tl_op_o(up1[8]),
        .up_ks_op_o(up1[7]), .up_amsen_op_o(up1[6]), .up_dt2_op_o(up1[5]),
        .up_d1l_op_o(up1[4]), .up_ar_op_o(up1[3]), .up_d1r_op_o(up1[2]),
        .up_d2r_op_o(up1[1]), .up_rr_op_o(up1[0])
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        int          inst;
        int          slot;
        logic [10:0] vec;
        logic [7:0]  dat;
    } exp_t;
    exp_t sb[$];

    // reference model: per instance an ordered list of accepted, not yet issued writes
    int          m_cnt;
    int          m_n [2];
    int          m_slot [2][2];
    logic [10:0] m_vec [2][2];
    logic [7:0]  m_dat [2][2];
    logic [7:0]  m_dout [2];
    logic        m_ovf [2];
    int          mp, mi;
    bit          cen_rand = 1'b0;

    function automatic int slot_of(input logic [7:0] a, input int k);
        logic [4:0] t;
        t = {a[3], a[4], a[2:0]};
        return (int'(t) + ((k == 0) ? OFS0 : OFS1)) % 32;
    endfunction

    // bit order: dt1 mul tl ks amsen dt2 d1l ar d1r d2r rr (10..0)
    function automatic logic [10:0] vec_of(input logic [7:0] a);
        case (a[7:5])
            3'b010:  return 11'((1 << 10) | (1 << 9));
            3'b011:  return 11'(1 << 8);
            3'b100:  return 11'((1 << 7) | (1 << 3));
            3'b101:  return 11'((1 << 6) | (1 << 2));
            3'b110:  return 11'((1 << 5) | (1 << 1));
            3'b111:  return 11'((1 << 4) | (1 << 0));
            default: return 11'd0;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            sb.delete();
            for (int k = 0; k < 2; k++) begin
                m_n[k]    = 0;
                m_dout[k] = 8'h00;
                m_ovf[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mp = m_n[k];
                if (mp > 0 && cen && m_cnt == m_slot[k][0]) begin
                    m_slot[k][0] = m_slot[k][1];
                    m_vec[k][0]  = m_vec[k][1];
                    m_dat[k][0]  = m_dat[k][1];
                    m_n[k]       = mp - 1;
                end
                if (wr && addr >= 8'h40) begin
                    if (mp < CAP) begin
                        mi = m_n[k];
                        m_slot[k][mi] = slot_of(addr, k);
                        m_vec[k][mi]  = vec_of(addr);
                        m_dat[k][mi]  = din;
                        m_n[k]        = mi + 1;
                        sb.push_back('{k, slot_of(addr, k), vec_of(addr), din});
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
                if (m_n[k] > 0) m_dout[k] = m_dat[k][0];
            end
            if (cen) m_cnt = (m_cnt + 1) % 32;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        ab, ao, eb;
            logic [7:0]  ad;
            logic [10:0] au;
            int          idx;
            bit          found;
            ab = (k == 0) ? busy0 : busy1;
            ao = (k == 0) ? ovf0 : ovf1;
            ad = (k == 0) ? dout0 : dout1;
            au = (k == 0) ? up0 : up1;
            eb = (CAP == 2) ? (m_n[k] == 2) : (m_n[k] > 0);
            chk("busy", k, 32'(ab), 32'(eb));
            chk("ovf", k, 32'(ao), 32'(m_ovf[k]));
            chk("dout", k, 32'(ad), 32'(m_dout[k]));
            if (au != 11'd0) begin
                found = 1'b0;
                idx = 0;
                for (int i = 0; i < sb.size(); i++) begin
                    if (!found && sb[i].inst == k) begin
                        found = 1'b1;
                        idx = i;
                    end
                end
                if (!found) begin
                    chk("spurious_strobe", k, 32'(au), 32'd0);
                end else begin
                    chk("strobe_slot", k, 32'(m_cnt), 32'(sb[idx].slot));
                    chk("strobe_set", k, 32'(au), 32'(sb[idx].vec));
                    chk("strobe_dout", k, 32'(ad), 32'(sb[idx].dat));
                    if (cen) sb.delete(idx);
                end
            end
        end
    end

    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cen = cen_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
        wr = 1'b1;
        addr = a;
        din = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_n[0] != 0 || m_n[1] != 0) && n < 400) begin
            tick();
            n++;
        end
        chk("idle_wait_in_bound", 0, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (m_cnt != v && n < 200) begin
            tick();
            n++;
        end
        chk("cnt_wait_in_bound", 0, 32'(n < 200), 32'd1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wr = 1'b0;
        addr = 8'h00;
        din = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        wait_cnt(3);
        do_wr(8'h60, 8'h7F);
        wait_idle();
        do_wr(8'h48, 8'h12);
        wait_idle();
        do_wr(8'h50, 8'h34);
        wait_idle();
        do_wr(8'hE1, 8'hA3);
        wait_idle();
        do_wr(8'h20, 8'h55);
        repeat (40) tick();

        wait_cnt(20);
        do_wr(8'h40, 8'h11);
        do_wr(8'h41, 8'h22);
        wait_idle();

        pulse_rst();
        wait_cnt(10);
        do_wr(8'h5F, 8'h99);
        tick();
        tick();
        pulse_rst();
        repeat (40) tick();

        cen_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) pulse_rst();
            wr = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(64, 255));
            din = 8'($urandom);
            tick();
        end
        wr = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
